// File: rtl/priority_encoder8_3_seq.sv
// priority_encoder8_3_seq: latches rising request edges and presents the top-priority
// pending index as a 3-bit code, held until the consumer acks it.
module priority_encoder8_3_seq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] A,
  output logic       valid,
  output logic [7:0] pending,
  output logic       drop
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state_q, state_d;
  logic [7:0] req_q, pending_q, pending_d, edg, clr;
  logic [2:0] a_q, a_d, sel, j;
  logic valid_q, valid_d, drop_q, drop_d, grant;
  always_comb begin
    sel = '0;
    j = '0;
    for (int i = 0; i < 8; i++) begin
      j = HIGH_FIRST ? 3'(i) : 3'(7 - i);
      if (pending_q[j]) sel = j;
    end
  end
  // set wins over clear so an edge on the bit being acked is not lost
  always_comb begin
    edg = req & ~req_q & {8{en}};
    clr = (state_q == PRESENT && ack) ? 8'd1 << a_q : 8'd0;
    pending_d = (pending_q & ~clr) | edg;
    drop_d = |(edg & pending_q & ~clr);
    grant = state_q == IDLE && |pending_q;
    state_d = grant ? PRESENT : (state_q == PRESENT && ack) ? IDLE : state_q;
    valid_d = state_d == PRESENT;
    a_d = grant ? sel : a_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= 8'hFF;
      pending_q <= '0;
      a_q <= '0;
      valid_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req;
      pending_q <= pending_d;
      a_q <= a_d;
      valid_q <= valid_d;
      drop_q <= drop_d;
    end
  end
  assign A = a_q;
  assign valid = valid_q;
  assign pending = pending_q;
  assign drop = drop_q;
endmodule

// File: tb/tb_priority_encoder8_3_seq.sv
// tb_priority_encoder8_3_seq: drives both priority orders with shared stimulus; grants are
// scoreboarded through per-instance queues filled by a behavioural model.
module tb_priority_encoder8_3_seq;
  logic clk = 0, rst = 1, en = 1, ack = 0;
  logic [7:0] req = 8'hFF;
  logic [2:0] a_o [2];
  logic v_o [2], d_o [2];
  logic [7:0] p_o [2];
  int total = 0, bad = 0;
  bit armed = 0;
  logic [7:0] m_pend [2];
  logic [2:0] m_a [2];
  bit m_busy [2], m_drop [2], prev_v [2];
  logic [7:0] m_rq;
  logic [2:0] exp_q0 [$], exp_q1 [$];

  always #5 clk = ~clk;

  priority_encoder8_3_seq #(.HIGH_FIRST(1'b1)) u_hi (.clk(clk), .rst(rst), .en(en), .req(req),
    .ack(ack), .A(a_o[0]), .valid(v_o[0]), .pending(p_o[0]), .drop(d_o[0]));
  priority_encoder8_3_seq #(.HIGH_FIRST(1'b0)) u_lo (.clk(clk), .rst(rst), .en(en), .req(req),
    .ack(ack), .A(a_o[1]), .valid(v_o[1]), .pending(p_o[1]), .drop(d_o[1]));

  function automatic logic [2:0] pick(logic [7:0] p, bit hf);
    for (int k = 0; k < 8; k++) begin
      int b = hf ? 7 - k : k;
      if (p[b]) return 3'(b);
    end
    return 3'd0;
  endfunction

  task automatic chk(string name, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      armed = 1;
      m_rq = 8'hFF;
      for (int d = 0; d < 2; d++) begin
        m_pend[d] = 0; m_a[d] = 0; m_busy[d] = 0; m_drop[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [7:0] e, c;
        e = req & ~m_rq & (en ? 8'hFF : 8'h00);
        c = (m_busy[d] && ack) ? 8'(1 << m_a[d]) : 8'h00;
        m_drop[d] = (e & m_pend[d] & ~c) != 0;
        if (!m_busy[d]) begin
          if (m_pend[d] != 0) begin
            m_a[d] = pick(m_pend[d], d == 0);
            m_busy[d] = 1;
            if (d == 0) exp_q0.push_back(m_a[d]); else exp_q1.push_back(m_a[d]);
          end
        end else if (ack) m_busy[d] = 0;
        m_pend[d] = (m_pend[d] & ~c) | e;
      end
      m_rq = req;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("valid[%0d]", d), 8'(v_o[d]), 8'(m_busy[d]));
        chk($sformatf("pending[%0d]", d), p_o[d], m_pend[d]);
        chk($sformatf("drop[%0d]", d), 8'(d_o[d]), 8'(m_drop[d]));
        if (!v_o[d]) chk($sformatf("held_A[%0d]", d), 8'(a_o[d]), 8'(m_a[d]));
        if (v_o[d] && !prev_v[d]) begin
          if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            total++; bad++;
            $display("FAIL grant[%0d] got=%0d want=none", d, a_o[d]);
          end else
            chk($sformatf("grant[%0d]", d), 8'(a_o[d]),
                8'(d == 0 ? exp_q0.pop_front() : exp_q1.pop_front()));
        end
        prev_v[d] = v_o[d];
      end
    end
  end

  task automatic cyc(input logic [7:0] r, input logic e, input logic a, input logic rs);
    @(negedge clk);
    req = r; en = e; ack = a; rst = rs;
  endtask

  initial begin
    repeat (3) cyc(8'hFF, 1, 0, 1);
    repeat (5) cyc(8'hFF, 1, 0, 0);
    cyc(8'h00, 1, 0, 0);
    repeat (4) cyc(8'h08, 1, 0, 0);
    cyc(8'h08, 1, 1, 0);
    repeat (2) cyc(8'h00, 1, 0, 0);
    cyc(8'h62, 1, 0, 0);
    repeat (2) cyc(8'h00, 1, 0, 0);
    repeat (12) cyc(8'h00, 1, 1, 0);
    cyc(8'h10, 1, 0, 0);
    repeat (3) cyc(8'h00, 1, 0, 0);
    cyc(8'h10, 1, 0, 0);
    cyc(8'h00, 1, 0, 0);
    cyc(8'h00, 1, 1, 0);
    repeat (3) cyc(8'h00, 1, 0, 0);
    cyc(8'h10, 1, 0, 0);
    repeat (3) cyc(8'h00, 1, 0, 0);
    cyc(8'h10, 1, 1, 0);
    repeat (3) cyc(8'h00, 1, 0, 0);
    cyc(8'h00, 1, 1, 0);
    repeat (2) cyc(8'h04, 0, 0, 0);
    repeat (3) cyc(8'h04, 1, 0, 0);
    cyc(8'h00, 1, 0, 0);
    cyc(8'h81, 1, 0, 0);
    repeat (2) cyc(8'h00, 1, 0, 0);
    cyc(8'h00, 1, 0, 1);
    cyc(8'h00, 1, 1, 0);
    cyc(8'h00, 1, 0, 0);
    for (int n = 0; n < 3000; n++)
      cyc(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 199) == 0);
    repeat (40) cyc(8'h00, 1, 1, 0);
    @(negedge clk);
    total++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      bad++;
      $display("FAIL unseen_grants got=%0d want=0", exp_q0.size() + exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/priority_encoder8_3_seq.md
Name: priority_encoder8_3_seq

Overview:
- Sequential 8-to-3 priority encoder with event latching and a valid/ack handshake; the inverse-direction companion of the team's 3-to-8 decoder.
- Captures rising edges on eight request lines into a pending register.
- Presents the highest-priority pending index as a 3-bit code (A2..A0 order, A[2] = MSB) and holds it until the consumer acknowledges.
- Used as the encode side of one-hot select/interrupt paths feeding the decoder elsewhere in the design.

Parameters:
- HIGH_FIRST, 1, priority order: 1 = req[7] highest, req[0] lowest; 0 = req[0] highest, req[7] lowest.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  capture enable; 0 discards new edges, while already-pending bits remain serviceable
- req  input  8  request lines, level, synchronous to clk
- ack  input  1  consumer accepts the current code; meaningful only while valid=1
- A  output  3  encoded index of the granted request
- valid  output  1  A holds a granted request
- pending  output  8  current pending register, for debug/status
- drop  output  1  one-cycle pulse: a new edge hit a bit that was already pending and not being cleared

Behaviour:
- Reset (rst=1 at a clk edge):
  - pending=0, A=0, valid=0, drop=0, state=IDLE.
  - req_q=8'hFF, so lines held high through reset are not reported as events.
- Edge detect:
  - edge = req & ~req_q & {8{en}}.
  - req_q <= req every non-reset cycle, regardless of en.
- Pending update, every cycle:
  - clr = one-hot(A) when (state==PRESENT && ack), else 0.
  - pending <= (pending & ~clr) | edge.
  - Set wins over clear: an edge on the bit being acked in the same cycle leaves it pending, so the event is not lost.
- drop <= |(edge & pending & ~clr), registered one-cycle pulse. The merged event is still counted once.
- FSM, 2 states:
  - IDLE: if pending != 0, A <= index of highest-priority set bit of pending (per HIGH_FIRST), valid <= 1, go PRESENT. Otherwise stay in IDLE, valid=0.
  - PRESENT: A and valid held stable. On ack: valid <= 0, go IDLE.
  - Minimum one idle cycle between consecutive grants.
- Latency: req rises before clk edge k → pending bit set after edge k → valid=1 after edge k+1 (2 cycles).
- No preemption: a higher-priority edge arriving in PRESENT waits until IDLE re-arbitrates.
- ack in IDLE is ignored and has no effect on pending.
- A is don't-care-free: it retains its last granted value while valid=0 (0 after reset).
- Reset mid-handshake (rst in PRESENT) returns to IDLE and clears pending; the in-flight grant is lost by design.
- All-zero pending: stays IDLE indefinitely; no spurious valid.

Test Plan:
- Reset with req=8'hFF held, release, hold 5 cycles → valid=0, pending=0, no edge captured; drop req to 0, raise req[3] → valid=1 two cycles after the rise, A=3.
- HIGH_FIRST=1: raise req[1], req[5], req[6] in the same cycle; ack each grant → grants in order A=6, 5, 1, each separated by ≥1 valid=0 cycle; pending goes 0x62→0x22→0x02→0x00.
- HIGH_FIRST=0: same stimulus → grants in order A=1, 5, 6.
- While A=4 is presented and not acked, re-pulse req[4] → drop pulses 1 cycle, pending[4] stays 1; ack → exactly one grant of A=4 occurred. Then pulse req[4] in the same cycle as ack → pending[4]=1 after the clear, second grant A=4 follows, drop=0.
- en=0 during a req[2] rising edge → no capture, pending=0; en=1 with req[2] still high → still no capture, since no new edge.
- Assert rst while valid=1 and A=7 with pending=0x81 → next cycle valid=0, pending=0, A=0; ack in IDLE → no change.
